div: RTL and testbench

// - Multi-cycle radix-2 restoring divider serving the execute stage for DIV/DIVU.
// - EX is the initiator: it raises start_i with operands and holds its stall request until ready_o.
// - The 64-bit result {remainder, quotient} is returned to EX, which writes remainder->HI and quotient->LO.

---
 rtl/div.sv | 171 +++++++++++++++++
 tb/tb_div.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// Returns {remainder, quotient}; EX holds start_i until ready_o and may annul at any time.
module div #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic [1:0]          state_o
);

  // Handshake: a request is accepted on a rising edge in FREE with start_i=1 and
  // annul_i=0; ready_o/result_o then hold until start_i drops or annul_i rises.

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [DATA_W-1:0] ONE     = DATA_W'(1);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W:0]   work_q, work_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_d;
  logic                ready_d;

  logic                accept;
  logic                abort;
  logic [DATA_W-1:0]   op1_abs, op2_abs;
  logic                trial_ge;
  logic [DATA_W-1:0]   trial_diff;
  logic [DATA_W-1:0]   quo_raw, rem_raw, quo_fix, rem_fix;

  assign accept = start_i & ~annul_i;
  assign abort  = annul_i | ~start_i;

  assign op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + ONE) : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + ONE) : opdata2_i;

  // The partial remainder window is DATA_W+1 bits wide, so compare at full width;
  // when it fits, the low DATA_W bits of the difference are the new remainder.
  assign trial_ge   = work_q[2*DATA_W:DATA_W] >= {1'b0, divisor_q};
  assign trial_diff = work_q[2*DATA_W-1:DATA_W] - divisor_q;

  assign quo_raw = work_q[DATA_W-1:0];
  assign rem_raw = work_q[2*DATA_W:DATA_W+1];
  assign quo_fix = neg_quo_q ? (~quo_raw + ONE) : quo_raw;
  assign rem_fix = neg_rem_q ? (~rem_raw + ONE) : rem_raw;

  assign state_o = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FREE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FREE: begin
        if (accept) state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
      end
      S_BYZERO: begin
        if (abort)              state_d = S_FREE;
        else if (cnt_q != '0)   state_d = S_END;
      end
      S_ON: begin
        if (abort)              state_d = S_FREE;
        else if (cnt_q == LAST) state_d = S_END;
      end
      S_END: begin
        if (abort) state_d = S_FREE;
      end
      default: state_d = S_FREE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_o;
    ready_d   = ready_o;
    case (state_q)
      S_FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (accept) begin
          cnt_d     = '0;
          work_d    = {{DATA_W{1'b0}}, op1_abs, 1'b0};
          divisor_d = op2_abs;
          neg_quo_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_rem_d = signed_div_i & opdata1_i[DATA_W-1];
        end
      end
      S_BYZERO: begin
        // Two cycles here keep the zero-divisor path at a fixed two-edge latency.
        if (abort) begin
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q == '0) begin
          cnt_d = CNT_ONE;
        end else begin
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      S_ON: begin
        if (abort) begin
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q != LAST) begin
          if (trial_ge) work_d = {trial_diff, work_q[DATA_W-1:0], 1'b1};
          else          work_d = work_q << 1;
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
        end
      end
      S_END: begin
        if (abort) begin
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        result_d = '0;
        ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_o  <= '0;
      ready_o   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_o  <= result_d;
      ready_o   <= ready_d;
    end
  end

endmodule

// File: tb/tb_div.sv
// Bench for div: directed vector table, randomized operands against an arithmetic
// reference model, and hand-written abort / annul / async-reset sequences.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic [1:0]  state_o;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[13];

  always #5 clk = ~clk;

  div #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .state_o      (state_o)
  );

  // Reference: truncating division on wide integers; zero divisor yields 0.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint na, nb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'({32'd0, a});
      nb = longint'({32'd0, b});
    end
    q = na / nb;
    r = na % nb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts edges after the accept edge until ready_o is seen (bounded).
  task automatic wait_ready(input int limit, output int lat);
    lat = 0;
    while (lat < limit) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ready_o) break;
    end
  endtask

  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp_res);
    logic [63:0] exp;
    int lat;
    int exp_lat;
    exp_lat = (b == 32'd0) ? 2 : 33;
    exp_q.push_back(exp_res);
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    #1;
    signed_div_i = 1'($urandom);
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    wait_ready(40, lat);
    exp = exp_q.pop_front();
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("result", result_o, exp);
    @(posedge clk);
    @(negedge clk);
    chk("hold_ready", 64'(ready_o), 64'd1);
    chk("hold_result", result_o, exp);
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("release_ready", 64'(ready_o), 64'd0);
    chk("release_result", result_o, 64'd0);
    chk("release_state", 64'(state_o), 64'd0);
  endtask

  task automatic accept_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    int lat;
    int seen;
    logic        rs;
    logic [31:0] ra, rb;

    tbl[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E};
    tbl[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD};
    tbl[2]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC};
    tbl[3]  = '{1'b0, 32'hFFFFFFFF,   32'd0,          64'h00000000_00000000};
    tbl[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000};
    tbl[5]  = '{1'b0, 32'd9,          32'd3,          64'h00000000_00000003};
    tbl[6]  = '{1'b0, 32'hFFFFFFFF,   32'h80000001,   64'h7FFFFFFE_00000001};
    tbl[7]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD};
    tbl[8]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003};
    tbl[9]  = '{1'b0, 32'd5,          32'd9,          64'h00000005_00000000};
    tbl[10] = '{1'b1, 32'h12345678,   32'd0,          64'h00000000_00000000};
    tbl[11] = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF};
    tbl[12] = '{1'b1, 32'h80000000,   32'd1,          64'h00000000_80000000};

    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    chk("reset_state", 64'(state_o), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 13; i++)
      do_op(tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].exp);

    // Annul at iteration 10, then a fresh 9/3 the very next cycle.
    accept_op(1'b0, 32'd1000, 32'd7);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready_o) seen++;
    end
    annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (ready_o) seen++;
    chk("annul_state", 64'(state_o), 64'd0);
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd9;
    opdata2_i    = 32'd3;
    @(posedge clk);
    wait_ready(40, lat);
    chk("annul_noready", 64'(seen), 64'd0);
    chk("after_annul_latency", 64'(lat), 64'd33);
    chk("after_annul_result", result_o, 64'h00000000_00000003);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Dropping start_i mid-division abandons it.
    accept_op(1'b0, 32'd50, 32'd5);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("drop_state", 64'(state_o), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) seen++;
    end
    chk("drop_noready", 64'(seen), 64'd0);

    // Annul while the result is being held.
    accept_op(1'b1, 32'hFFFFFF9C, 32'd7);
    wait_ready(40, lat);
    chk("end_annul_pre", result_o, ref_div(1'b1, 32'hFFFFFF9C, 32'd7));
    annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("end_annul_ready", 64'(ready_o), 64'd0);
    chk("end_annul_result", result_o, 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    @(negedge clk);

    // Async reset mid-iteration, off the clock edge.
    accept_op(1'b0, 32'd123456, 32'd789);
    repeat (15) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("areset_on_state", 64'(state_o), 64'd0);
    chk("areset_on_ready", 64'(ready_o), 64'd0);
    chk("areset_on_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);

    // Async reset while a result is held clears it at once.
    accept_op(1'b0, 32'd100, 32'd7);
    wait_ready(40, lat);
    #2 rst = 1'b0;
    #1;
    chk("areset_end_ready", 64'(ready_o), 64'd0);
    chk("areset_end_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Randomized operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'h80000000;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      do_op(rs, ra, rb, ref_div(rs, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
